// File: rtl/id_pipe_if.sv
// Fetch/decode/execute handshake bundle for the id_pipe decode stage.
// "master" is the surrounding pipeline; "slave" is the decode stage.
interface id_pipe_if #(
  parameter int NUM_FWD = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            pc;
  logic [31:0]            inst;
  logic                   re1;
  logic                   re2;
  logic [4:0]             raddr1;
  logic [4:0]             raddr2;
  logic [31:0]            rdata1;
  logic [31:0]            rdata2;
  logic [NUM_FWD-1:0]     fwd_we;
  logic [5*NUM_FWD-1:0]   fwd_waddr;
  logic [32*NUM_FWD-1:0]  fwd_wdata;
  logic [NUM_FWD-1:0]     fwd_is_load;
  logic                   out_valid;
  logic                   out_ready;
  logic [2:0]             alusel;
  logic [7:0]             aluop;
  logic                   we;
  logic [4:0]             waddr;
  logic [31:0]            opv1;
  logic [31:0]            opv2;
  logic                   illegal;

  modport master (
    output in_valid, pc, inst, rdata1, rdata2,
    output fwd_we, fwd_waddr, fwd_wdata, fwd_is_load, out_ready,
    input  in_ready, re1, re2, raddr1, raddr2,
    input  out_valid, alusel, aluop, we, waddr, opv1, opv2, illegal
  );

  modport slave (
    input  in_valid, pc, inst, rdata1, rdata2,
    input  fwd_we, fwd_waddr, fwd_wdata, fwd_is_load, out_ready,
    output in_ready, re1, re2, raddr1, raddr2,
    output out_valid, alusel, aluop, we, waddr, opv1, opv2, illegal
  );
endinterface

// File: rtl/id_pipe.sv
// RV32I integer-ALU decode stage with operand forwarding and load-use stall.
// Macro ID_PIPE_FWD_EN: defined = forwarded data used; undefined = any source match stalls.
module id_pipe #(
  parameter int NUM_FWD = 2
) (
  input logic      clk,
  input logic      rst,
  id_pipe_if.slave bus
);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_ARITH = 3'd1;
  localparam logic [2:0] SEL_LOGIC = 3'd2;
  localparam logic [2:0] SEL_SHIFT = 3'd3;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_SLT  = 8'd2;
  localparam logic [7:0] OP_SLTU = 8'd3;
  localparam logic [7:0] OP_XOR  = 8'd4;
  localparam logic [7:0] OP_OR   = 8'd5;
  localparam logic [7:0] OP_AND  = 8'd6;
  localparam logic [7:0] OP_SLL  = 8'd7;
  localparam logic [7:0] OP_SRL  = 8'd8;
  localparam logic [7:0] OP_SRA  = 8'd9;

  // Returns {legal, alusel, aluop}; is_reg selects OP (register) funct7 rules over OP_IMM.
  function automatic logic [11:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                             input logic is_reg);
    logic       ok;
    logic [2:0] sel;
    logic [7:0] op;
    logic       f7_zero;
    logic       f7_alt;
    f7_zero = (f7 == 7'b0000000);
    f7_alt  = (f7 == 7'b0100000);
    ok  = !is_reg || f7_zero;
    sel = SEL_ARITH;
    op  = OP_ADD;
    case (f3)
      3'b000: begin
        op = (is_reg && f7_alt) ? OP_SUB : OP_ADD;
        ok = !is_reg || f7_zero || f7_alt;
      end
      3'b001: begin sel = SEL_SHIFT; op = OP_SLL; ok = f7_zero; end
      3'b010: op = OP_SLT;
      3'b011: op = OP_SLTU;
      3'b100: begin sel = SEL_LOGIC; op = OP_XOR; end
      3'b101: begin
        sel = SEL_SHIFT;
        op  = f7_alt ? OP_SRA : OP_SRL;
        ok  = f7_zero || f7_alt;
      end
      3'b110: begin sel = SEL_LOGIC; op = OP_OR; end
      3'b111: begin sel = SEL_LOGIC; op = OP_AND; end
    endcase
    return {ok, sel, op};
  endfunction

  function automatic logic signed [31:0] imm_i(input logic [31:0] w);
    logic signed [11:0] s12;
    logic signed [31:0] s32;
    s12 = w[31:20];
    s32 = s12;
    return s32;
  endfunction

  logic [11:0] w_dec_i;
  logic [11:0] w_dec_r;
  logic        w_legal;
  logic        w_use1;
  logic        w_use2;
  logic        w_pc_op1;
  logic [2:0]  w_sel;
  logic [7:0]  w_op;
  logic [31:0] w_imm;
  logic [4:0]  w_raddr1;
  logic [4:0]  w_raddr2;
  logic        w_re1;
  logic        w_re2;
  logic        w_hit1;
  logic        w_hit2;
  logic        w_chk1;
  logic        w_chk2;
  logic        w_stall;
  logic        w_in_ready;
  logic        w_xfer;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_opv1;
  logic [31:0] w_opv2;
`ifdef ID_PIPE_FWD_EN
  logic        w_load1;
  logic        w_load2;
  logic [31:0] w_fdata1;
  logic [31:0] w_fdata2;
`endif

  logic        r_vld_p1;
  logic [2:0]  r_alusel_p1;
  logic [7:0]  r_aluop_p1;
  logic        r_we_p1;
  logic [4:0]  r_waddr_p1;
  logic [31:0] r_opv1_p1;
  logic [31:0] r_opv2_p1;
  logic        r_illegal_p1;

  assign w_dec_i  = alu_decode(bus.inst[14:12], bus.inst[31:25], 1'b0);
  assign w_dec_r  = alu_decode(bus.inst[14:12], bus.inst[31:25], 1'b1);
  assign w_raddr1 = bus.inst[19:15];
  assign w_raddr2 = bus.inst[24:20];

  always_comb begin
    w_legal  = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_pc_op1 = 1'b0;
    w_sel    = SEL_NONE;
    w_op     = OP_ADD;
    w_imm    = '0;
    case (bus.inst[6:0])
      OPC_OP_IMM: begin
        w_legal = w_dec_i[11];
        w_sel   = w_dec_i[10:8];
        w_op    = w_dec_i[7:0];
        w_use1  = 1'b1;
        w_imm   = (w_dec_i[10:8] == SEL_SHIFT) ? {27'd0, bus.inst[24:20]} : imm_i(bus.inst);
      end
      OPC_OP: begin
        w_legal = w_dec_r[11];
        w_sel   = w_dec_r[10:8];
        w_op    = w_dec_r[7:0];
        w_use1  = 1'b1;
        w_use2  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_legal  = 1'b1;
        w_sel    = SEL_ARITH;
        w_op     = OP_ADD;
        w_pc_op1 = (bus.inst[6:0] == OPC_AUIPC);
        w_imm    = {bus.inst[31:12], 12'd0};
      end
      default: ;
    endcase
  end

  // Illegal words never enable a read, so they can never stall.
  assign w_re1  = w_legal && w_use1;
  assign w_re2  = w_legal && w_use2;
  assign w_chk1 = w_re1 && (w_raddr1 != 5'd0);
  assign w_chk2 = w_re2 && (w_raddr2 != 5'd0);

  // Walk from oldest to youngest so the lowest index wins.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
`ifdef ID_PIPE_FWD_EN
    w_load1  = 1'b0;
    w_load2  = 1'b0;
    w_fdata1 = '0;
    w_fdata2 = '0;
`endif
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (bus.fwd_we[i] && (bus.fwd_waddr[5*i +: 5] == w_raddr1)) begin
        w_hit1 = 1'b1;
`ifdef ID_PIPE_FWD_EN
        w_load1  = bus.fwd_is_load[i];
        w_fdata1 = bus.fwd_wdata[32*i +: 32];
`endif
      end
      if (bus.fwd_we[i] && (bus.fwd_waddr[5*i +: 5] == w_raddr2)) begin
        w_hit2 = 1'b1;
`ifdef ID_PIPE_FWD_EN
        w_load2  = bus.fwd_is_load[i];
        w_fdata2 = bus.fwd_wdata[32*i +: 32];
`endif
      end
    end
  end

`ifdef ID_PIPE_FWD_EN
  assign w_stall = (w_chk1 && w_hit1 && w_load1) || (w_chk2 && w_hit2 && w_load2);
  assign w_src1  = !w_chk1 ? 32'd0 : (w_hit1 ? w_fdata1 : bus.rdata1);
  assign w_src2  = !w_chk2 ? 32'd0 : (w_hit2 ? w_fdata2 : bus.rdata2);
`else
  assign w_stall = (w_chk1 && w_hit1) || (w_chk2 && w_hit2);
  assign w_src1  = w_chk1 ? bus.rdata1 : 32'd0;
  assign w_src2  = w_chk2 ? bus.rdata2 : 32'd0;
`endif

  assign w_opv1 = w_re1 ? w_src1 : (w_pc_op1 ? bus.pc : 32'd0);
  assign w_opv2 = w_re2 ? w_src2 : (w_legal ? w_imm : 32'd0);

  assign w_in_ready = !rst && !w_stall && (!r_vld_p1 || bus.out_ready);
  assign w_xfer     = bus.in_valid && w_in_ready;

  // Stage boundary: decode (p0, combinational) -> execute handoff registers (p1).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_alusel_p1  <= '0;
      r_aluop_p1   <= '0;
      r_we_p1      <= 1'b0;
      r_waddr_p1   <= '0;
      r_opv1_p1    <= '0;
      r_opv2_p1    <= '0;
      r_illegal_p1 <= 1'b0;
    end else if (w_xfer) begin
      r_vld_p1     <= 1'b1;
      r_alusel_p1  <= w_legal ? w_sel : SEL_NONE;
      r_aluop_p1   <= w_legal ? w_op : OP_ADD;
      r_we_p1      <= w_legal;
      r_waddr_p1   <= w_legal ? bus.inst[11:7] : 5'd0;
      r_opv1_p1    <= w_opv1;
      r_opv2_p1    <= w_opv2;
      r_illegal_p1 <= !w_legal;
    end else if (r_vld_p1 && bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.re1       = w_re1;
  assign bus.re2       = w_re2;
  assign bus.raddr1    = w_raddr1;
  assign bus.raddr2    = w_raddr2;
  assign bus.out_valid = r_vld_p1;
  assign bus.alusel    = r_alusel_p1;
  assign bus.aluop     = r_aluop_p1;
  assign bus.we        = r_we_p1;
  assign bus.waddr     = r_waddr_p1;
  assign bus.opv1      = r_opv1_p1;
  assign bus.opv2      = r_opv2_p1;
  assign bus.illegal   = r_illegal_p1;
endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed steps then random traffic against a mask/match
// instruction-table model with a one-slot output register model.
`timescale 1ns/1ps
module tb_id_pipe;
  localparam int NUM_FWD = 2;
  localparam int NPAT    = 21;

  localparam logic [2:0] S_ARITH = 3'd1;
  localparam logic [2:0] S_LOGIC = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;

  localparam logic [7:0] O_ADD = 8'd0, O_SUB = 8'd1, O_SLT = 8'd2, O_SLTU = 8'd3, O_XOR = 8'd4;
  localparam logic [7:0] O_OR  = 8'd5, O_AND = 8'd6, O_SLL = 8'd7, O_SRL  = 8'd8, O_SRA = 8'd9;

  localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_SH = 3'd2, K_LUI = 3'd3, K_AUIPC = 3'd4;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [2:0]  kind;
  } pat_t;

  typedef struct packed {
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] opv1;
    logic [31:0] opv2;
    logic        illegal;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_pipe_if #(.NUM_FWD(NUM_FWD)) bus ();
  id_pipe #(.NUM_FWD(NUM_FWD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  logic exp_ov;
  res_t exp_r;
  logic last_rdy;

  function automatic pat_t pat(input int k);
    pat_t p;
    case (k)
      0:  p = '{32'hFE00707F, 32'h00000033, S_ARITH, O_ADD,  K_R};
      1:  p = '{32'hFE00707F, 32'h40000033, S_ARITH, O_SUB,  K_R};
      2:  p = '{32'hFE00707F, 32'h00001033, S_SHIFT, O_SLL,  K_R};
      3:  p = '{32'hFE00707F, 32'h00002033, S_ARITH, O_SLT,  K_R};
      4:  p = '{32'hFE00707F, 32'h00003033, S_ARITH, O_SLTU, K_R};
      5:  p = '{32'hFE00707F, 32'h00004033, S_LOGIC, O_XOR,  K_R};
      6:  p = '{32'hFE00707F, 32'h00005033, S_SHIFT, O_SRL,  K_R};
      7:  p = '{32'hFE00707F, 32'h40005033, S_SHIFT, O_SRA,  K_R};
      8:  p = '{32'hFE00707F, 32'h00006033, S_LOGIC, O_OR,   K_R};
      9:  p = '{32'hFE00707F, 32'h00007033, S_LOGIC, O_AND,  K_R};
      10: p = '{32'h0000707F, 32'h00000013, S_ARITH, O_ADD,  K_I};
      11: p = '{32'h0000707F, 32'h00002013, S_ARITH, O_SLT,  K_I};
      12: p = '{32'h0000707F, 32'h00003013, S_ARITH, O_SLTU, K_I};
      13: p = '{32'h0000707F, 32'h00004013, S_LOGIC, O_XOR,  K_I};
      14: p = '{32'h0000707F, 32'h00006013, S_LOGIC, O_OR,   K_I};
      15: p = '{32'h0000707F, 32'h00007013, S_LOGIC, O_AND,  K_I};
      16: p = '{32'hFE00707F, 32'h00001013, S_SHIFT, O_SLL,  K_SH};
      17: p = '{32'hFE00707F, 32'h00005013, S_SHIFT, O_SRL,  K_SH};
      18: p = '{32'hFE00707F, 32'h40005013, S_SHIFT, O_SRA,  K_SH};
      19: p = '{32'h0000007F, 32'h00000037, S_ARITH, O_ADD,  K_LUI};
      20: p = '{32'h0000007F, 32'h00000017, S_ARITH, O_ADD,  K_AUIPC};
      default: p = '{32'h00000000, 32'h00000001, 3'd0, 8'd0, K_R};
    endcase
    return p;
  endfunction

  function automatic int lookup(input logic [31:0] w);
    pat_t p;
    for (int k = 0; k < NPAT; k++) begin
      p = pat(k);
      if ((w & p.mask) == p.match) return k;
    end
    return -1;
  endfunction

  function automatic int first_src(input logic [4:0] a);
    for (int i = 0; i < NUM_FWD; i++)
      if (bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == a) return i;
    return -1;
  endfunction

  function automatic logic src_blocks(input logic [4:0] a);
    int s;
    if (a == 5'd0) return 1'b0;
    s = first_src(a);
    if (s < 0) return 1'b0;
`ifdef ID_PIPE_FWD_EN
    return bus.fwd_is_load[s];
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rdata);
    int s;
    if (a == 5'd0) return 32'd0;
    s = first_src(a);
`ifdef ID_PIPE_FWD_EN
    if (s >= 0) return bus.fwd_wdata[32*s +: 32];
`endif
    return rdata;
  endfunction

  function automatic logic uses_rs1(input logic [31:0] w);
    int k;
    k = lookup(w);
    return (k >= 0) && (pat(k).kind inside {K_R, K_I, K_SH});
  endfunction

  function automatic logic uses_rs2(input logic [31:0] w);
    int k;
    k = lookup(w);
    return (k >= 0) && (pat(k).kind == K_R);
  endfunction

  function automatic logic model_stall(input logic [31:0] w);
    return (uses_rs1(w) && src_blocks(w[19:15])) || (uses_rs2(w) && src_blocks(w[24:20]));
  endfunction

  function automatic res_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    res_t r;
    pat_t p;
    int   k;
    r = '0;
    k = lookup(w);
    if (k < 0) begin
      r.illegal = 1'b1;
      return r;
    end
    p = pat(k);
    r.alusel = p.sel;
    r.aluop  = p.op;
    r.we     = 1'b1;
    r.waddr  = w[11:7];
    case (p.kind)
      K_R:   begin r.opv1 = operand(w[19:15], bus.rdata1); r.opv2 = operand(w[24:20], bus.rdata2); end
      K_I:   begin r.opv1 = operand(w[19:15], bus.rdata1); r.opv2 = {{20{w[31]}}, w[31:20]}; end
      K_SH:  begin r.opv1 = operand(w[19:15], bus.rdata1); r.opv2 = {27'd0, w[24:20]}; end
      K_LUI: begin r.opv1 = 32'd0; r.opv2 = {w[31:12], 12'd0}; end
      default: begin r.opv1 = pc; r.opv2 = {w[31:12], 12'd0}; end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    pat_t        p;
    int          sel;
    sel = $urandom_range(0, NPAT + 2);
    if (sel >= NPAT) return $urandom;
    p = pat(sel);
    w = ($urandom & ~p.mask) | p.match;
    w[19:15] = 5'($urandom_range(0, 3));
    if (p.kind == K_R) w[24:20] = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) w[25] = ~w[25];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic ld);
    bus.fwd_we[i]            = we;
    bus.fwd_waddr[5*i +: 5]  = a;
    bus.fwd_wdata[32*i +: 32] = d;
    bus.fwd_is_load[i]       = ld;
  endtask

  task automatic clear_src();
    bus.fwd_we      = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = '0;
    bus.fwd_is_load = '0;
  endtask

  // One clock: check combinational outputs, advance the model at the edge, check registers.
  task automatic cycle();
    logic exp_rdy;
    logic xfer;
    res_t nx;
    #1;
    exp_rdy = !rst && !model_stall(bus.inst) && (!exp_ov || bus.out_ready);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("re1",      32'(bus.re1),      32'(uses_rs1(bus.inst)));
    chk("re2",      32'(bus.re2),      32'(uses_rs2(bus.inst)));
    chk("raddr1",   32'(bus.raddr1),   32'(bus.inst[19:15]));
    chk("raddr2",   32'(bus.raddr2),   32'(bus.inst[24:20]));
    xfer = bus.in_valid && exp_rdy;
    nx   = model_decode(bus.inst, bus.pc);
    last_rdy = exp_rdy;
    @(posedge clk);
    if (rst) begin
      exp_ov = 1'b0;
      exp_r  = '0;
    end else if (xfer) begin
      exp_ov = 1'b1;
      exp_r  = nx;
    end else if (exp_ov && bus.out_ready) begin
      exp_ov = 1'b0;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("alusel",    32'(bus.alusel),    32'(exp_r.alusel));
    chk("aluop",     32'(bus.aluop),     32'(exp_r.aluop));
    chk("we",        32'(bus.we),        32'(exp_r.we));
    chk("waddr",     32'(bus.waddr),     32'(exp_r.waddr));
    chk("opv1",      bus.opv1,           exp_r.opv1);
    chk("opv2",      bus.opv2,           exp_r.opv2);
    chk("illegal",   32'(bus.illegal),   32'(exp_r.illegal));
  endtask

  initial begin
    logic [31:0] held_opv1;
    exp_ov = 1'b0;
    exp_r  = '0;
    last_rdy = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.pc = 32'd0;
    bus.inst = 32'd0;
    bus.rdata1 = 32'd0;
    bus.rdata2 = 32'd0;
    bus.out_ready = 1'b1;
    clear_src();

    cycle();
    cycle();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,-1
    bus.in_valid = 1'b1;
    bus.inst = 32'hFFF00093;
    cycle();
    bus.in_valid = 1'b0;
    chk("addi_ov",    32'(bus.out_valid), 32'd1);
    chk("addi_opv1",  bus.opv1, 32'h0);
    chk("addi_opv2",  bus.opv2, 32'hFFFFFFFF);
    chk("addi_we",    32'(bus.we), 32'd1);
    chk("addi_waddr", 32'(bus.waddr), 32'd1);

    // ADD x3,x1,x2 with two sources targeting x1
    bus.in_valid = 1'b1;
    bus.inst = 32'h002081B3;
    bus.rdata1 = 32'd5;
    bus.rdata2 = 32'd7;
    set_src(0, 1'b1, 5'd1, 32'h10, 1'b0);
    set_src(1, 1'b1, 5'd1, 32'h20, 1'b0);
    cycle();
`ifdef ID_PIPE_FWD_EN
    chk("fwd_opv1", bus.opv1, 32'h10);
    chk("fwd_opv2", bus.opv2, 32'd7);
`else
    chk("nofwd_stall", 32'(bus.in_ready), 32'd0);
    clear_src();
    cycle();
    chk("nofwd_opv1", bus.opv1, 32'd5);
    chk("nofwd_opv2", bus.opv2, 32'd7);
`endif

    // Drain, then load-use on x1
    bus.in_valid = 1'b0;
    clear_src();
    cycle();
    bus.in_valid = 1'b1;
    set_src(0, 1'b1, 5'd1, 32'h44, 1'b1);
    cycle();
    chk("lu_in_ready", 32'(bus.in_ready), 32'd0);
    chk("lu_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef ID_PIPE_FWD_EN
    set_src(0, 1'b1, 5'd1, 32'h44, 1'b0);
    cycle();
    chk("lu_opv1", bus.opv1, 32'h44);
`else
    clear_src();
    cycle();
    chk("lu_opv1", bus.opv1, 32'd5);
`endif
    chk("lu_accept", 32'(bus.out_valid), 32'd1);
    clear_src();

    // LUI x5,0x12345 then AUIPC x6,0x1 at pc 0x100
    bus.inst = 32'h123452B7;
    cycle();
    chk("lui_opv1", bus.opv1, 32'h0);
    chk("lui_opv2", bus.opv2, 32'h12345000);
    bus.pc = 32'h100;
    bus.inst = 32'h00001317;
    cycle();
    chk("auipc_opv1", bus.opv1, 32'h100);
    chk("auipc_opv2", bus.opv2, 32'h1000);

    // Back-pressure for three cycles, then reset pulse
    bus.out_ready = 1'b0;
    bus.inst = 32'h00500393;
    held_opv1 = bus.opv1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_opv1", bus.opv1, held_opv1);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("bp_rst_ov", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // Illegal encodings
    bus.inst = 32'hFFFFFFFF;
    cycle();
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_we", 32'(bus.we), 32'd0);
    bus.inst = 32'h0220D1B3;
    cycle();
    chk("srl_f7_ill", 32'(bus.illegal), 32'd1);

    // Random traffic; fetch holds its word while it is not accepted
    for (int n = 0; n < 800; n++) begin
      if (!(bus.in_valid && !last_rdy)) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.inst = rand_inst();
        bus.pc = $urandom & 32'hFFFFFFFC;
      end
      bus.rdata1 = $urandom;
      bus.rdata2 = $urandom;
      for (int i = 0; i < NUM_FWD; i++)
        set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 3) == 0));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
